// File: rtl/ascon_sigma_pkg.sv
// Shared definitions for the Ascon sigma sequencer: FSM states,
// per-lane rotation constants and the largest legal lane index.
package ascon_sigma_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        R0L  = 3'd1,
        R0H  = 3'd2,
        R1L  = 3'd3,
        R1H  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam logic [2:0] MAX_LANE = 3'd4;

    // Rotation amounts for the five Ascon state lanes
    localparam logic [5:0] ROT_R0 [0:4] = '{6'd19, 6'd61, 6'd1, 6'd10, 6'd7};
    localparam logic [5:0] ROT_R1 [0:4] = '{6'd28, 6'd39, 6'd6, 6'd17, 6'd41};

    // Pick the first or second rotation amount of a lane; illegal lanes map to 0
    function automatic logic [5:0] rot_amount(input logic [2:0] lane, input logic use_r1);
        logic [5:0] amount;
        case (lane)
            3'd0:    amount = use_r1 ? ROT_R1[0] : ROT_R0[0];
            3'd1:    amount = use_r1 ? ROT_R1[1] : ROT_R0[1];
            3'd2:    amount = use_r1 ? ROT_R1[2] : ROT_R0[2];
            3'd3:    amount = use_r1 ? ROT_R1[3] : ROT_R0[3];
            3'd4:    amount = use_r1 ? ROT_R1[4] : ROT_R0[4];
            default: amount = 6'd0;
        endcase
        return amount;
    endfunction

endpackage

// File: rtl/ascon_sigma_seq_rot.sv
// Combinational 64-bit rotate-right by 0..31 built as a five-stage
// log shifter; only the selected 32-bit half of the result is output.
module ascon_rot64_half (
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    input  logic [4:0]  shamt,
    input  logic        sel_h,
    output logic [31:0] result
);

    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    logic [63:0] s4;
    logic [63:0] s5;

    // Each stage rotates by a power of two when its shamt bit is set
    always_comb begin
        s0     = {hi, lo};
        s1     = shamt[0] ? {s0[0],     s0[63:1]}  : s0;
        s2     = shamt[1] ? {s1[1:0],   s1[63:2]}  : s1;
        s3     = shamt[2] ? {s2[3:0],   s2[63:4]}  : s2;
        s4     = shamt[3] ? {s3[7:0],   s3[63:8]}  : s3;
        s5     = shamt[4] ? {s4[15:0],  s4[63:16]} : s4;
        result = sel_h ? s5[63:32] : s5[31:0];
    end

endmodule

// File: rtl/ascon_sigma_seq.sv
// Multi-cycle Ascon sigma engine: one 32-bit rotate half per cycle,
// XOR-accumulated into the lane value, returned over valid/ready.
module ascon_sigma_seq
    import ascon_sigma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_x_lo,
    input  logic [31:0] req_x_hi,
    input  logic [2:0]  req_lane,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_lo,
    output logic [31:0] rsp_hi,
    output logic        rsp_err
);

    state_t      state;
    state_t      state_next;
    logic [31:0] op_lo;
    logic [31:0] op_hi;
    logic [31:0] acc_lo;
    logic [31:0] acc_hi;
    logic [2:0]  lane_q;
    logic        err_q;
    logic        lane_legal;
    logic        use_r1;
    logic        sel_h;
    logic        rot_en;
    logic [5:0]  amount;
    logic [31:0] rot_hi;
    logic [31:0] rot_lo;
    logic [31:0] rot_out;

    assign lane_legal = (req_lane <= MAX_LANE);

    // Rotations of 32 or more become a half-swap plus a short rotate
    assign amount = rot_amount(lane_q, use_r1);
    assign rot_hi = amount[5] ? op_lo : op_hi;
    assign rot_lo = amount[5] ? op_hi : op_lo;

    ascon_rot64_half u_rot (
        .hi     (rot_hi),
        .lo     (rot_lo),
        .shamt  (amount[4:0]),
        .sel_h  (sel_h),
        .result (rot_out)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: four compute steps, illegal lanes skip straight to DONE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (req_valid) state_next = lane_legal ? R0L : DONE;
            R0L:     state_next = R0H;
            R0H:     state_next = R1L;
            R1L:     state_next = R1H;
            R1H:     state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: handshakes and rotate-step selects depend only on state
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == DONE);
        use_r1    = (state == R1L) || (state == R1H);
        sel_h     = (state == R0H) || (state == R1H);
        rot_en    = (state == R0L) || (state == R0H) || (state == R1L) || (state == R1H);
    end

    // Datapath: capture the lane on accept, fold in one rotated half per step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_lo  <= '0;
            op_hi  <= '0;
            acc_lo <= '0;
            acc_hi <= '0;
            lane_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                acc_lo <= req_x_lo;
                acc_hi <= req_x_hi;
                err_q  <= ~lane_legal;
                if (lane_legal) begin
                    op_lo  <= req_x_lo;
                    op_hi  <= req_x_hi;
                    lane_q <= req_lane;
                end
            end else if (rot_en) begin
                if (sel_h) acc_hi <= acc_hi ^ rot_out;
                else       acc_lo <= acc_lo ^ rot_out;
            end else if (state == DONE && rsp_ready) begin
                err_q <= 1'b0;
            end
        end
    end

    assign rsp_lo  = acc_lo;
    assign rsp_hi  = acc_hi;
    assign rsp_err = err_q;

endmodule

// File: tb/tb_ascon_sigma_seq.sv
// Self-checking bench for ascon_sigma_seq against a ror64-based sigma model.
module tb_ascon_sigma_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_x_lo;
    logic [31:0] req_x_hi;
    logic [2:0]  req_lane;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;

    int assertions = 0;
    int failures   = 0;

    int r0_tab [5] = '{19, 61, 1, 10, 7};
    int r1_tab [5] = '{28, 39, 6, 17, 41};

    ascon_sigma_seq dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x_lo  (req_x_lo),
        .req_x_hi  (req_x_hi),
        .req_lane  (req_lane),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_lo    (rsp_lo),
        .rsp_hi    (rsp_hi),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference sigma; illegal lanes return x unchanged
    function automatic logic [63:0] sigma_ref(input logic [63:0] x, input int lane);
        if (lane > 4) return x;
        return x ^ ror64(x, r0_tab[lane]) ^ ror64(x, r1_tab[lane]);
    endfunction

    // Issue one request, wait for its response, optionally acknowledge it
    task automatic run_req(input logic [63:0] x, input logic [2:0] lane, input bit ack,
                           output logic [63:0] res, output logic err, output int lat,
                           output bit ok);
        int guard = 0;
        ok  = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_x_lo  = x[31:0];
        req_x_hi  = x[63:32];
        req_lane  = lane;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        res = {rsp_hi, rsp_lo};
        err = rsp_err;
        if (ack && ok) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        assertions++;
        if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
        assertions++;
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        assertions++;
        if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_err got %b want 0", rsp_err); end
        assertions++;
        if ({rsp_hi, rsp_lo} !== 64'h0) begin failures++; $display("[TB] FAIL reset_rsp got %h want 0", {rsp_hi, rsp_lo}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [63:0] xs   [3] = '{64'h1, 64'h1, 64'h1};
        logic [2:0]  ls   [3] = '{3'd0, 3'd1, 3'd2};
        logic [63:0] want [3] = '{64'h0000201000000001, 64'h0000000002000009, 64'h8400000000000001};
        logic [63:0] res;
        logic        err;
        int          lat;
        bit          ok;
        for (int i = 0; i < 3; i++) begin
            run_req(xs[i], ls[i], 1'b1, res, err, lat, ok);
            assertions++;
            if (!ok || res !== want[i]) begin failures++; $display("[TB] FAIL directed_lane%0d got %h want %h", ls[i], res, want[i]); end
            assertions++;
            if (!ok || res !== sigma_ref(xs[i], ls[i])) begin failures++; $display("[TB] FAIL directed_model%0d got %h want %h", ls[i], res, sigma_ref(xs[i], ls[i])); end
            assertions++;
            if (err !== 1'b0) begin failures++; $display("[TB] FAIL directed_err%0d got %b want 0", ls[i], err); end
            assertions++;
            if (lat != 5) begin failures++; $display("[TB] FAIL directed_latency%0d got %0d want 5", ls[i], lat); end
        end
    endtask

    task automatic test_constant_lanes();
        logic [63:0] res;
        logic        err;
        int          lat;
        bit          ok;
        for (int l = 0; l < 5; l++) begin
            run_req(64'hFFFFFFFFFFFFFFFF, 3'(l), 1'b1, res, err, lat, ok);
            assertions++;
            if (!ok || res !== 64'hFFFFFFFFFFFFFFFF) begin failures++; $display("[TB] FAIL ones_lane%0d got %h want ffffffffffffffff", l, res); end
            run_req(64'h0, 3'(l), 1'b1, res, err, lat, ok);
            assertions++;
            if (!ok || res !== 64'h0) begin failures++; $display("[TB] FAIL zero_lane%0d got %h want 0", l, res); end
        end
    endtask

    task automatic test_illegal_lane();
        logic [63:0] res;
        logic        err;
        int          lat;
        bit          ok;
        run_req(64'h0123456789ABCDEF, 3'd5, 1'b1, res, err, lat, ok);
        assertions++;
        if (!ok || res !== 64'h0123456789ABCDEF) begin failures++; $display("[TB] FAIL illegal_value got %h want 0123456789abcdef", res); end
        assertions++;
        if (err !== 1'b1) begin failures++; $display("[TB] FAIL illegal_err got %b want 1", err); end
        assertions++;
        if (lat != 1) begin failures++; $display("[TB] FAIL illegal_latency got %0d want 1", lat); end
        run_req(64'h0123456789ABCDEF, 3'd3, 1'b1, res, err, lat, ok);
        assertions++;
        if (err !== 1'b0) begin failures++; $display("[TB] FAIL after_illegal_err got %b want 0", err); end
        assertions++;
        if (!ok || res !== sigma_ref(64'h0123456789ABCDEF, 3)) begin failures++; $display("[TB] FAIL after_illegal_value got %h want %h", res, sigma_ref(64'h0123456789ABCDEF, 3)); end
    endtask

    task automatic test_stall();
        logic [63:0] x;
        logic [63:0] res;
        logic        err;
        int          lat;
        bit          ok;
        bit          stable = 1'b1;
        x = {$urandom, $urandom};
        run_req(x, 3'd4, 1'b0, res, err, lat, ok);
        assertions++;
        if (!ok || res !== sigma_ref(x, 4)) begin failures++; $display("[TB] FAIL stall_value got %h want %h", res, sigma_ref(x, 4)); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_hi, rsp_lo} !== res || rsp_err !== err)
                stable = 1'b0;
        end
        assertions++;
        if (!stable) begin failures++; $display("[TB] FAIL stall_hold got %b want 1", stable); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        assertions++;
        if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_ready got %b want 1", req_ready); end
        assertions++;
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_release_valid got %b want 0", rsp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] x;
        logic [2:0]  lane;
        logic [63:0] res;
        logic        err;
        int          lat;
        bit          ok;
        for (int i = 0; i < 24; i++) begin
            x    = {$urandom, $urandom};
            lane = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            run_req(x, lane, 1'b1, res, err, lat, ok);
            assertions++;
            if (!ok || res !== sigma_ref(x, int'(lane)) || err !== (lane > 3'd4) ||
                lat != ((lane > 3'd4) ? 1 : 5)) begin
                failures++;
                $display("[TB] FAIL b2b_%0d lane %0d got %h err %b lat %0d want %h err %b",
                         i, lane, res, err, lat, sigma_ref(x, int'(lane)), lane > 3'd4);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] x;
        logic [63:0] res;
        logic        err;
        int          lat;
        bit          ok;
        bit          quiet = 1'b1;
        x = {$urandom, $urandom};
        @(negedge clk);
        req_valid = 1'b1;
        req_x_lo  = x[31:0];
        req_x_hi  = x[63:32];
        req_lane  = 3'd1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        assertions++;
        if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL midreset_valid got %b want 0", rsp_valid); end
        assertions++;
        if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL midreset_ready got %b want 1", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) quiet = 1'b0;
        end
        assertions++;
        if (!quiet) begin failures++; $display("[TB] FAIL midreset_no_response got %b want 1", quiet); end
        x = {$urandom, $urandom};
        run_req(x, 3'd2, 1'b1, res, err, lat, ok);
        assertions++;
        if (!ok || res !== sigma_ref(x, 2) || err !== 1'b0) begin failures++; $display("[TB] FAIL midreset_fresh got %h want %h", res, sigma_ref(x, 2)); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_x_lo  = '0;
        req_x_hi  = '0;
        req_lane  = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_directed();
        test_constant_lanes();
        test_illegal_lane();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/ascon_sigma_seq.md
# ascon_sigma_seq

Multi-cycle sequencer for the Ascon linear diffusion layer Σ_i(x) = x ^ ror64(x, r0_i) ^ ror64(x, r1_i) on RV32. It takes one 64-bit lane (two 32-bit halves) and a lane index, then drives a shared 32-bit-output rotate unit one half-word per cycle. It XOR-accumulates the four rotated halves and returns the 64-bit result over a valid/ready handshake. It sits beside the Ascon custom-instruction datapath as the engine behind a multi-cycle Σ instruction.

## Interface
- No parameters. Rotation constants are fixed and live in the package.
- clk  in  1  — sole clock, rising edge.
- rst  in  1  — asynchronous, active-high reset.
- req_valid  in  1  — request present.
- req_ready  out  1  — block can accept a request.
- req_x_lo  in  32  — lane bits [31:0].
- req_x_hi  in  32  — lane bits [63:32].
- req_lane  in  3  — lane index 0..4. Values 5..7 are illegal.
- rsp_valid  out  1  — result present.
- rsp_ready  in  1  — consumer accepts the result.
- rsp_lo  out  32  — result bits [31:0].
- rsp_hi  out  32  — result bits [63:32].
- rsp_err  out  1  — request carried an illegal lane index.

## Operation
- Rotation pairs (r0, r1) by lane: 0:(19,28), 1:(61,39), 2:(1,6), 3:(10,17), 4:(7,41).
- ror64(x, n) = (x >> n) | (x << (64−n)).
- The rotate unit takes hi/lo operands, a 5-bit shamt and a half select.
  - For n < 32: operands are {hi, lo} and shamt = n.
  - For n ≥ 32: operands are swapped ({lo, hi}) and shamt = n − 32.
- FSM states: IDLE, R0L, R0H, R1L, R1H, DONE.
- IDLE
  - req_ready = 1.
  - On req_valid with a legal lane: latch x into an operand register, load the accumulator with x, latch the lane, then go to R0L.
  - On req_valid with an illegal lane: accumulator = x, rsp_err = 1, go directly to DONE.
- Each compute state issues one rotate half:
  - R0L: rotation r0, low half.
  - R0H: rotation r0, high half.
  - R1L: rotation r1, low half.
  - R1H: rotation r1, high half.
  - At the clock edge, the rotate output is XORed into the matching accumulator half.
- The operand register holds the original x throughout. Rotations never read the accumulator.
- DONE
  - rsp_valid = 1. rsp_lo/rsp_hi/rsp_err are driven from registers.
  - On rsp_ready: go to IDLE and clear rsp_err.
- No new request is accepted outside IDLE, so the block has at most one request in flight.
- Reset mid-operation: the in-flight request is discarded with no response. The FSM returns to IDLE.

## Timing
- Reset values (asynchronous):
  - state = IDLE, so req_ready = 1.
  - rsp_valid = 0, rsp_err = 0.
  - rsp_lo = rsp_hi = 0.
  - Accumulator, operand register and lane register all 0.
- Legal lane: the request is accepted at edge E0. rsp_valid is first high in the cycle after E4. That is 4 compute cycles, result visible 5 cycles after acceptance.
- Illegal lane: rsp_valid is high in the cycle after E0.
- rsp_lo/rsp_hi/rsp_err stay stable while rsp_valid = 1 and rsp_ready = 0, for any number of stall cycles.
- Response handshake at edge Ek: req_ready = 1 in the following cycle. There is no same-cycle response-to-request bypass.
- Minimum request-to-request spacing is 6 cycles for legal lanes.
- req_ready and rsp_valid are pure state decodes with no combinational path from any input.
- The rotate unit is purely combinational, so there is no added latency per step.

## Structure
- Package ascon_sigma_pkg holds:
  - the state enum;
  - the 5-entry rotation constant table (r0, r1 as 6-bit values);
  - the lane-legality constant (MAX_LANE = 4).
- Sub-module ascon_rot64_half: combinational 64-bit rotate-right by a 5-bit amount, built as a log-shifter. Inputs are hi, lo, shamt and sel_h; output is the selected 32-bit half. It is the only rotate hardware in the block.
- Top level contains the FSM, the operand/accumulator/lane registers, the operand-swap mux and the shamt computation.

## Test plan
- x = 0x0000000000000001, lane 0 → rsp = 0x0000201000000001, err = 0, rsp_valid 5 cycles after acceptance.
- x = 0x0000000000000001, lane 1 → 0x0000000002000009. Lane 2 → 0x8400000000000001. Together these exercise the ≥32 swap path and the single-bit shift.
- x = 0xFFFFFFFFFFFFFFFF on every lane → 0xFFFFFFFFFFFFFFFF. x = 0 on every lane → 0.
- req_lane = 5, x = 0x0123456789ABCDEF → rsp = x, err = 1, one cycle after acceptance. The next legal request returns err = 0.
- Hold rsp_ready = 0 for 10 cycles in DONE → outputs stable and req_ready = 0 throughout. Then a 1-cycle rsp_ready → req_ready = 1 next cycle. Back-to-back random requests are checked against a ror64 reference model.
- Assert rst asynchronously during R1L → immediate IDLE, rsp_valid = 0, no response emitted. A fresh request afterwards returns the correct value.
